// File: rtl/gray_counter.sv
// Registered binary counter with a registered Gray-code twin for CDC pointers.
// Latency 1 cycle; optional up/down counting via GRAY_COUNTER_UPDOWN_EN (undefined = up-only).
module gray_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             dir,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO      = '0;
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT ^ (INIT >> 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("gray_counter: WIDTH must be in 2..32");
    end

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             count_up;
    logic [WIDTH-1:0] step_bin;
    logic             step_wraps;

`ifdef GRAY_COUNTER_UPDOWN_EN
    assign count_up = dir;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign count_up   = 1'b1;
`endif

    // Next value of a count step and whether that step rolls over.
    always_comb begin
        step_bin   = bin_q + ONE;
        step_wraps = (bin_q == ALL_ONES);
`ifdef GRAY_COUNTER_UPDOWN_EN
        if (!count_up) begin
            step_bin   = bin_q - ONE;
            step_wraps = (bin_q == ZERO);
        end
`endif
    end

    // Gray register is encoded from the next binary value so both flops stay in step.
    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = load_bin;
            gray_d = load_bin ^ (load_bin >> 1);
        end else if (ena) begin
            bin_d  = step_bin;
            gray_d = step_bin ^ (step_bin >> 1);
            wrap_d = step_wraps;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            bin_q  <= INIT;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter (WIDTH=4, INIT=5): driver queues expectations, monitor checks.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       ena = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_bin = 4'h0;
    logic       dir = 1'b1;
    logic [3:0] bin_out;
    logic [3:0] gray_out;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
        bit         onebit;
    } exp_t;

    exp_t exp_q[$];

    gray_counter #(.WIDTH(4), .INIT(4'd5)) dut (
        .clk(clk), .nrst(nrst), .ena(ena), .load(load), .load_bin(load_bin),
        .dir(dir), .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic step(input string name, input logic rst_n, input logic ld, input logic en,
                        input logic d, input logic [3:0] lb, input logic [3:0] eb,
                        input logic [3:0] eg, input logic ew, input bit ob);
        exp_t e;
        @(negedge clk);
        nrst = rst_n; load = ld; ena = en; dir = d; load_bin = lb;
        e.name = name; e.bin = eb; e.gray = eg; e.wrap = ew; e.onebit = ob;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, sampled 1 time unit after the edge.
    initial begin
        exp_t       e;
        logic [3:0] prev_gray = 4'h0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bin_out !== e.bin) begin
                    errors++;
                    $display("FAIL %s bin_out: got %h want %h", e.name, bin_out, e.bin);
                end
                checks++;
                if (gray_out !== e.gray) begin
                    errors++;
                    $display("FAIL %s gray_out: got %h want %h", e.name, gray_out, e.gray);
                end
                checks++;
                if (wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL %s wrap: got %b want %b", e.name, wrap, e.wrap);
                end
                checks++;
                if (gray_out !== (bin_out ^ (bin_out >> 1))) begin
                    errors++;
                    $display("FAIL %s invariant: gray %h bin %h", e.name, gray_out, bin_out);
                end
                if (e.onebit) begin
                    checks++;
                    if ($countones(gray_out ^ prev_gray) != 1) begin
                        errors++;
                        $display("FAIL %s onebit: gray %h prev %h", e.name, gray_out, prev_gray);
                    end
                end
                prev_gray = gray_out;
            end
        end
    end

    initial begin
        //   name        nrst ld en dir lb     bin    gray   wrap onebit
        step("reset",    0,   0, 0, 1,  4'h0, 4'h5, 4'h7, 0, 0);
        step("load0",    1,   1, 0, 1,  4'h0, 4'h0, 4'h0, 0, 0);
        step("up1",      1,   0, 1, 1,  4'h0, 4'h1, 4'h1, 0, 1);
        step("up2",      1,   0, 1, 1,  4'h0, 4'h2, 4'h3, 0, 1);
        step("up3",      1,   0, 1, 1,  4'h0, 4'h3, 4'h2, 0, 1);
        step("up4",      1,   0, 1, 1,  4'h0, 4'h4, 4'h6, 0, 1);
        step("up5",      1,   0, 1, 1,  4'h0, 4'h5, 4'h7, 0, 1);
        step("up6",      1,   0, 1, 1,  4'h0, 4'h6, 4'h5, 0, 1);
        step("up7",      1,   0, 1, 1,  4'h0, 4'h7, 4'h4, 0, 1);
        step("up8",      1,   0, 1, 1,  4'h0, 4'h8, 4'hC, 0, 1);
        step("loadF",    1,   1, 1, 1,  4'hF, 4'hF, 4'h8, 0, 0);
        step("wrap_up",  1,   0, 1, 1,  4'h0, 4'h0, 4'h0, 1, 1);
        step("hold",     1,   0, 0, 1,  4'h0, 4'h0, 4'h0, 0, 0);
        step("loadB",    1,   1, 1, 1,  4'hB, 4'hB, 4'hE, 0, 0);
        step("loadF2",   1,   1, 0, 1,  4'hF, 4'hF, 4'h8, 0, 0);
        step("wrap_up2", 1,   0, 1, 1,  4'h0, 4'h0, 4'h0, 1, 1);
        step("load0w",   1,   1, 1, 1,  4'h0, 4'h0, 4'h0, 0, 0);
        step("load9",    1,   1, 0, 1,  4'h9, 4'h9, 4'hD, 0, 0);
        step("rst_mid",  0,   1, 1, 1,  4'h3, 4'h5, 4'h7, 0, 0);
        step("loadF3",   1,   1, 0, 1,  4'hF, 4'hF, 4'h8, 0, 0);
        step("rst_drop", 0,   0, 1, 1,  4'h0, 4'h5, 4'h7, 0, 0);
        step("load0d",   1,   1, 0, 0,  4'h0, 4'h0, 4'h0, 0, 0);
`ifdef GRAY_COUNTER_UPDOWN_EN
        step("down1",    1,   0, 1, 0,  4'h0, 4'hF, 4'h8, 1, 1);
        step("down2",    1,   0, 1, 0,  4'h0, 4'hE, 4'h9, 0, 1);
        step("turn_up",  1,   0, 1, 1,  4'h0, 4'hF, 4'h8, 0, 1);
        step("wrap_up3", 1,   0, 1, 1,  4'h0, 4'h0, 4'h0, 1, 1);
        step("hold2",    1,   0, 0, 0,  4'h0, 4'h0, 4'h0, 0, 0);
`else
        step("down1",    1,   0, 1, 0,  4'h0, 4'h1, 4'h1, 0, 1);
        step("down2",    1,   0, 1, 0,  4'h0, 4'h2, 4'h3, 0, 1);
        step("turn_up",  1,   0, 1, 1,  4'h0, 4'h3, 4'h2, 0, 1);
        step("up_after", 1,   0, 1, 1,  4'h0, 4'h4, 4'h6, 0, 1);
        step("hold2",    1,   0, 0, 0,  4'h0, 4'h4, 4'h6, 0, 0);
`endif
        @(negedge clk);
        ena = 1'b0; load = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Registered binary counter with a registered Gray-code output, built as the binary-to-Gray counterpart of `gray2bin`. It produces glitch-free Gray pointers for clock-domain crossings, such as async FIFO write/read pointers and cross-domain event counters. The receiving domain synchronizes `gray_out` and decodes it with `gray2bin`. Every output is a flop output, with no combinational logic between the register and the port.

## Interface
- `WIDTH`, default 8: counter width in bits; legal range is 2 to 32.
- `INIT`, default 0: binary value loaded at reset.

- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `nrst` input, 1 bit: synchronous, active-low reset.
- `ena` input, 1 bit: count enable; the counter steps once per cycle while it is high.
- `load` input, 1 bit: synchronous load strobe.
- `load_bin` input, `WIDTH` bits: binary value captured when `load` is high.
- `dir` input, 1 bit: count direction, 1 = up and 0 = down. It only has an effect when `GRAY_COUNTER_UPDOWN_EN` is defined.
- `bin_out` output, `WIDTH` bits: registered binary count.
- `gray_out` output, `WIDTH` bits: registered Gray code of `bin_out`.
- `wrap` output, 1 bit: single-cycle pulse that marks a counter roll-over.

## Operation
- Priority per rising edge: `nrst` low, then `load`, then `ena`, then hold.
- Reset values:
  - `bin_out` = `INIT`.
  - `gray_out` = `INIT ^ (INIT >> 1)`.
  - `wrap` = 0.
- Load:
  - `bin_out` takes `load_bin`.
  - `gray_out` takes `load_bin ^ (load_bin >> 1)`.
  - `wrap` goes to 0, even if `load_bin` is 0 or all-ones.
  - `ena` is ignored in a load cycle.
- Count:
  - The next binary value is `bin_out ± 1`, modulo 2^WIDTH.
  - `gray_out` takes the Gray encoding of that next binary value in the same edge, not the encoding of the current value.
  - The invariant `gray_out == bin_out ^ (bin_out >> 1)` holds at every cycle.
- Wrap:
  - `wrap` is 1 in the cycle after a count step from all-ones to 0 (up), or from 0 to all-ones (down).
  - Otherwise `wrap` is 0, including in hold cycles.
- CDC guarantee: for any count step, `gray_out` changes exactly one bit. Load steps carry no such guarantee; the user must quiesce the crossing around a load.
- No state machine. State is the binary register, the Gray register and the wrap flop. The binary and Gray registers are kept as separate flops so that `gray_out` is never a decoded combinational net.

## Timing
- Latency: 1 cycle from a sampled `ena`, `load` or `nrst` to the updated outputs.
- Throughput: one step per cycle with `ena` held high continuously.
- `wrap` aligns with the cycle in which `bin_out` shows the wrapped value.
- Reset mid-count: on the edge where `nrst` is sampled low, the counter returns to `INIT` regardless of `ena` or `load`. A `wrap` pulse that was pending is dropped.
- `dir` is sampled in the same edge as `ena`. A direction change takes effect on that step, with no turnaround cycle.

## Configuration
- Macro: `GRAY_COUNTER_UPDOWN_EN`.
- Defined: `dir` selects up or down counting as described above. A down-count wrap from 0 to all-ones pulses `wrap`.
- Not defined:
  - The counter is up-only.
  - `dir` is kept on the port list for a stable interface, but is ignored and left unconnected internally.
  - No down-count logic is synthesized.

## Test plan
- Reset/INIT: `WIDTH`=4, `INIT`=5, `nrst` low for one edge. Required: `bin_out`=0x5, `gray_out`=0x7, `wrap`=0.
- Up sequence: `WIDTH`=4, `INIT`=0, `ena` high for 8 cycles. Required: `gray_out` = 1, 3, 2, 6, 7, 5, 4, C; exactly one bit changes per step; `wrap` stays 0.
- Wrap: load 0xF, then `ena` for 1 cycle. Required: `gray_out` goes 0x8 to 0x0, `bin_out`=0, `wrap`=1 for exactly one cycle, then 0 with `ena` low.
- Load priority: `load`=1 and `ena`=1 with `load_bin`=0xB. Required: `bin_out`=0xB, `gray_out`=0xE, `wrap`=0. Loading 0x0 also gives `wrap`=0.
- Reset mid-operation: `ena` high, `nrst` low at count 0x9 together with `load`=1. Required: next cycle `bin_out`=`INIT` and `wrap`=0.
- Down count (macro defined): from 0, `dir`=0 with `ena` for 2 cycles. Required: `bin_out` 0xF then 0xE, `gray_out` 0x8 then 0x9, `wrap`=1 only after the first step.
- Down count (macro undefined): the same stimulus counts up, giving 0x1 then 0x2.
- All scenarios: a checker asserts the `gray_out`/`bin_out` invariant every cycle.
